// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback
//
// Write-back stage sequencer: the writer side of the decode-stage register
// file. Accepts retired results from the MEM stage, stalls the MEM stage while
// a load waits for data memory, then aligns and extends the returned data and
// pulses the register file write port for one cycle.
//
// Parameters
//   DATA_WIDTH  width of results, memory read data and write data (>= 16)
//   TIMEOUT     cycles a load may wait for mem_rvalid before it is abandoned
//
// Ports
//   clk         system clock, all state updates on posedge
//   rst         synchronous active-high reset
//   wb_valid    MEM stage presents a retiring instruction
//   wb_ready    instruction accepted this cycle (high only in IDLE)
//   wb_rd       destination register index
//   wb_result   ALU/JAL result for non-loads
//   wb_is_load  instruction is a load
//   wb_funct3   load type (LB/LH/LW/LBU/LHU)
//   wb_addr_lo  load byte address bits [1:0]
//   mem_rvalid  data memory read response valid
//   mem_rdata   word-aligned data memory read word
//   wen         register file write enable (one-cycle pulse)
//   rd          register file write index (holds when wen=0)
//   data_out    register file write data (holds when wen=0)
//   busy        high while waiting for load data
//   err         one-cycle pulse: illegal funct3, misaligned load or timeout
// ---------------------------------------------------------------------------
module reg_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_result,
  input  logic                  wb_is_load,
  input  logic [2:0]            wb_funct3,
  input  logic [1:0]            wb_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wen,
  output logic [4:0]            rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  err
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_LOAD = 1'b1;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One spare bit keeps the counter at least one bit wide even for TIMEOUT=1.
  localparam int            CW           = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  logic [0:0]            state;
  logic [CW-1:0]         cnt;
  logic [4:0]            ld_rd;
  logic [2:0]            ld_funct3;
  logic [1:0]            ld_addr;

  logic                  ld_illegal;
  logic                  ld_misaligned;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_value;

  assign wb_ready = (state == IDLE);
  assign busy     = (state == WAIT_LOAD);

  // Legality of a load is judged on the incoming fields at accept time so a
  // bad load never enters WAIT_LOAD.
  always_comb begin
    ld_illegal    = (wb_funct3 == 3'b011) || (wb_funct3 == 3'b110) ||
                    (wb_funct3 == 3'b111);
    ld_misaligned = (((wb_funct3 == F3_LH) || (wb_funct3 == F3_LHU)) && wb_addr_lo[0]) ||
                    ((wb_funct3 == F3_LW) && (wb_addr_lo != 2'b00));
  end

  // Field extraction from the aligned memory word using the captured load
  // type and address; only legal types can reach WAIT_LOAD, so LW is the
  // default.
  always_comb begin
    ld_byte  = mem_rdata[8*ld_addr +: 8];
    ld_half  = mem_rdata[16*ld_addr[1] +: 16];
    ld_value = mem_rdata;
    case (ld_funct3)
      F3_LB:   ld_value = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_value = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      F3_LH:   ld_value = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      F3_LHU:  ld_value = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_value = mem_rdata;
    endcase
  end

  // Sequencer. wen and err default low so they are single-cycle pulses; rd
  // and data_out only change on a real write, so writes to x0 leave them
  // untouched. mem_rvalid is checked before the timeout so a response in the
  // final waiting cycle still completes the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wen       <= 1'b0;
      err       <= 1'b0;
      rd        <= '0;
      data_out  <= '0;
      ld_rd     <= '0;
      ld_funct3 <= '0;
      ld_addr   <= '0;
    end else begin
      wen <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_valid && wb_ready) begin
            if (!wb_is_load) begin
              if (wb_rd != 5'd0) begin
                wen      <= 1'b1;
                rd       <= wb_rd;
                data_out <= wb_result;
              end
            end else if (ld_illegal || ld_misaligned) begin
              err <= 1'b1;
            end else begin
              state     <= WAIT_LOAD;
              cnt       <= '0;
              ld_rd     <= wb_rd;
              ld_funct3 <= wb_funct3;
              ld_addr   <= wb_addr_lo;
            end
          end
        end
        WAIT_LOAD: begin
          if (mem_rvalid) begin
            state <= IDLE;
            if (ld_rd != 5'd0) begin
              wen      <= 1'b1;
              rd       <= ld_rd;
              data_out <= ld_value;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// ---------------------------------------------------------------------------
// tb_reg_writeback
//
// Directed self-checking bench for reg_writeback. Inputs change 1 ns after a
// rising edge, outputs are checked 1 ns after the next rising edge.
// ---------------------------------------------------------------------------
module tb_reg_writeback;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        wb_is_load;
  logic [2:0]  wb_funct3;
  logic [1:0]  wb_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wen;
  logic [4:0]  rd;
  logic [31:0] data_out;
  logic        busy;
  logic        err;

  int checkCount = 0;
  int errorCount = 0;

  reg_writeback #(.DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rd      (wb_rd),
    .wb_result  (wb_result),
    .wb_is_load (wb_is_load),
    .wb_funct3  (wb_funct3),
    .wb_addr_lo (wb_addr_lo),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wen        (wen),
    .rd         (rd),
    .data_out   (data_out),
    .busy       (busy),
    .err        (err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive every MEM-stage and memory input in one call.
  task automatic applyStimulus(input logic v, input logic [4:0] r, input logic [31:0] res,
                               input logic ld, input logic [2:0] f3, input logic [1:0] a,
                               input logic rv, input logic [31:0] rdat);
    wb_valid   = v;
    wb_rd      = r;
    wb_result  = res;
    wb_is_load = ld;
    wb_funct3  = f3;
    wb_addr_lo = a;
    mem_rvalid = rv;
    mem_rdata  = rdat;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'b00, 1'b0, 32'h0);
  endtask

  // One comparison: counts it, and on mismatch counts the failure and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyIdle();
    step();
    step();

    // Reset state
    checkOutput("reset_wen",      32'(wen),      32'd0);
    checkOutput("reset_rd",       32'(rd),       32'd0);
    checkOutput("reset_data",     data_out,      32'd0);
    checkOutput("reset_err",      32'(err),      32'd0);
    checkOutput("reset_busy",     32'(busy),     32'd0);
    checkOutput("reset_ready",    32'(wb_ready), 32'd1);
    rst = 1'b0;
    step();

    // Non-load write
    applyStimulus(1'b1, 5'd5, 32'h1234_5678, 1'b0, 3'b000, 2'b00, 1'b0, 32'h0);
    step();
    applyIdle();
    checkOutput("alu_wen",        32'(wen),      32'd1);
    checkOutput("alu_rd",         32'(rd),       32'd5);
    checkOutput("alu_data",       data_out,      32'h1234_5678);
    step();
    checkOutput("alu_wen_pulse",  32'(wen),      32'd0);
    checkOutput("alu_data_hold",  data_out,      32'h1234_5678);

    // Back-to-back non-loads
    applyStimulus(1'b1, 5'd1, 32'h0000_0011, 1'b0, 3'b000, 2'b00, 1'b0, 32'h0);
    step();
    checkOutput("b2b_wen1",       32'(wen),      32'd1);
    checkOutput("b2b_rd1",        32'(rd),       32'd1);
    applyStimulus(1'b1, 5'd2, 32'h0000_0022, 1'b0, 3'b000, 2'b00, 1'b0, 32'h0);
    step();
    applyIdle();
    checkOutput("b2b_wen2",       32'(wen),      32'd1);
    checkOutput("b2b_rd2",        32'(rd),       32'd2);
    checkOutput("b2b_data2",      data_out,      32'h0000_0022);
    step();

    // LB, byte 3, data two cycles after accept
    applyStimulus(1'b1, 5'd7, 32'h0, 1'b1, 3'b000, 2'b11, 1'b0, 32'h0);
    step();
    applyIdle();
    checkOutput("lb_ready_wait",  32'(wb_ready), 32'd0);
    checkOutput("lb_busy_wait",   32'(busy),     32'd1);
    checkOutput("lb_wen_wait",    32'(wen),      32'd0);
    step();
    checkOutput("lb_busy_wait2",  32'(busy),     32'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'b00, 1'b1, 32'h80FF_0011);
    step();
    applyIdle();
    checkOutput("lb_wen",         32'(wen),      32'd1);
    checkOutput("lb_rd",          32'(rd),       32'd7);
    checkOutput("lb_data",        data_out,      32'hFFFF_FF80);
    checkOutput("lb_busy_done",   32'(busy),     32'd0);
    step();
    checkOutput("lb_wen_pulse",   32'(wen),      32'd0);

    // LBU, same stimulus
    applyStimulus(1'b1, 5'd7, 32'h0, 1'b1, 3'b100, 2'b11, 1'b0, 32'h0);
    step();
    applyIdle();
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'b00, 1'b1, 32'h80FF_0011);
    step();
    applyIdle();
    checkOutput("lbu_wen",        32'(wen),      32'd1);
    checkOutput("lbu_data",       data_out,      32'h0000_0080);
    step();

    // LH, upper halfword, rvalid in the first waiting cycle
    applyStimulus(1'b1, 5'd8, 32'h0, 1'b1, 3'b001, 2'b10, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'b00, 1'b1, 32'h8001_7FFF);
    step();
    applyIdle();
    checkOutput("lh_wen",         32'(wen),      32'd1);
    checkOutput("lh_rd",          32'(rd),       32'd8);
    checkOutput("lh_data",        data_out,      32'hFFFF_8001);
    step();

    // LHU misaligned
    applyStimulus(1'b1, 5'd9, 32'h0, 1'b1, 3'b101, 2'b01, 1'b0, 32'h0);
    step();
    applyIdle();
    checkOutput("lhu_mis_err",    32'(err),      32'd1);
    checkOutput("lhu_mis_wen",    32'(wen),      32'd0);
    checkOutput("lhu_mis_ready",  32'(wb_ready), 32'd1);
    step();
    checkOutput("lhu_err_pulse",  32'(err),      32'd0);

    // LW misaligned and illegal funct3
    applyStimulus(1'b1, 5'd9, 32'h0, 1'b1, 3'b010, 2'b10, 1'b0, 32'h0);
    step();
    applyIdle();
    checkOutput("lw_mis_err",     32'(err),      32'd1);
    checkOutput("lw_mis_busy",    32'(busy),     32'd0);
    applyStimulus(1'b1, 5'd9, 32'h0, 1'b1, 3'b011, 2'b00, 1'b0, 32'h0);
    step();
    applyIdle();
    checkOutput("f3_ill_err",     32'(err),      32'd1);
    checkOutput("f3_ill_busy",    32'(busy),     32'd0);
    step();

    // Timeout: 16 waiting cycles without rvalid
    applyStimulus(1'b1, 5'd10, 32'h0, 1'b1, 3'b010, 2'b00, 1'b0, 32'h0);
    step();
    applyIdle();
    for (int i = 0; i < 15; i++) step();
    checkOutput("to_busy_15",     32'(busy),     32'd1);
    checkOutput("to_err_15",      32'(err),      32'd0);
    step();
    checkOutput("to_err",         32'(err),      32'd1);
    checkOutput("to_wen",         32'(wen),      32'd0);
    checkOutput("to_busy",        32'(busy),     32'd0);
    step();
    checkOutput("to_err_pulse",   32'(err),      32'd0);

    // rvalid on the 16th waiting cycle wins over the timeout
    applyStimulus(1'b1, 5'd11, 32'h0, 1'b1, 3'b010, 2'b00, 1'b0, 32'h0);
    step();
    applyIdle();
    for (int i = 0; i < 15; i++) step();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'b00, 1'b1, 32'hCAFE_BABE);
    step();
    applyIdle();
    checkOutput("late_wen",       32'(wen),      32'd1);
    checkOutput("late_err",       32'(err),      32'd0);
    checkOutput("late_rd",        32'(rd),       32'd11);
    checkOutput("late_data",      data_out,      32'hCAFE_BABE);
    step();

    // Writes to x0 never raise wen
    applyStimulus(1'b1, 5'd0, 32'h0000_DEAD, 1'b0, 3'b000, 2'b00, 1'b0, 32'h0);
    checkOutput("x0_alu_ready",   32'(wb_ready), 32'd1);
    step();
    applyIdle();
    checkOutput("x0_alu_wen",     32'(wen),      32'd0);
    applyStimulus(1'b1, 5'd0, 32'h0, 1'b1, 3'b010, 2'b00, 1'b0, 32'h0);
    step();
    applyIdle();
    checkOutput("x0_lw_busy",     32'(busy),     32'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'b00, 1'b1, 32'h1111_2222);
    step();
    applyIdle();
    checkOutput("x0_lw_wen",      32'(wen),      32'd0);
    checkOutput("x0_lw_err",      32'(err),      32'd0);
    checkOutput("x0_lw_ready",    32'(wb_ready), 32'd1);
    step();

    // Reset during a load aborts it
    applyStimulus(1'b1, 5'd12, 32'h0, 1'b1, 3'b010, 2'b00, 1'b0, 32'h0);
    step();
    applyIdle();
    for (int i = 0; i < 3; i++) step();
    checkOutput("rst_mid_busy",   32'(busy),     32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst_mid_ready",  32'(wb_ready), 32'd1);
    checkOutput("rst_mid_err",    32'(err),      32'd0);
    checkOutput("rst_mid_rd",     32'(rd),       32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'b00, 1'b1, 32'h5555_5555);
    step();
    applyIdle();
    checkOutput("rst_mid_wen",    32'(wen),      32'd0);
    checkOutput("rst_mid_err2",   32'(err),      32'd0);
    checkOutput("rst_mid_busy2",  32'(busy),     32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-back stage sequencer. It is the writer side of the decode-stage register file.
- Accepts retired results from the MEM stage, holds the pipeline while a load waits for data memory, and aligns and extends load data.
- Drives the register file write port (wen / rd / data) as registered one-cycle pulses, sampled by the register file on the following negedge.

Parameters:
- DATA_WIDTH, 32, width of result, memory read data and write data.
- TIMEOUT, 16, max cycles in WAIT_LOAD before the load is abandoned (>=1).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- wb_valid  in  1  MEM stage presents a retiring instruction.
- wb_ready  out  1  block accepts the instruction this cycle (transfer = wb_valid & wb_ready).
- wb_rd  in  5  destination register index.
- wb_result  in  DATA_WIDTH  ALU/JAL result for non-loads.
- wb_is_load  in  1  instruction is a load.
- wb_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- wb_addr_lo  in  2  load byte address bits [1:0].
- mem_rvalid  in  1  data memory read response valid.
- mem_rdata  in  DATA_WIDTH  data memory read word, aligned to a word boundary.
- wen  out  1  register file write enable.
- rd  out  5  register file write index.
- data_out  out  DATA_WIDTH  register file write data.
- busy  out  1  high while in WAIT_LOAD.
- err  out  1  one-cycle pulse: illegal funct3, misaligned load, or timeout.

Behaviour:
Reset (rst=1 at posedge):
- State goes to IDLE.
- wen=0, rd=0, data_out=0, err=0, busy=0; the timeout counter clears.
- Reset in WAIT_LOAD aborts the load: no write, no err.

State machine:
- Two states, IDLE and WAIT_LOAD.
- wb_ready = (state==IDLE); combinational from state only.
- busy = (state==WAIT_LOAD).

IDLE, transfer with wb_is_load=0:
- Next cycle: wen=1, rd=wb_rd, data_out=wb_result.
- Stay in IDLE. Back-to-back transfers produce back-to-back wen pulses.

IDLE, transfer with wb_is_load=1:
- Capture wb_rd, wb_funct3, wb_addr_lo.
- Legality check at accept:
  - funct3 in {011,110,111} is illegal.
  - LH/LHU with addr_lo[0]=1 is misaligned.
  - LW with addr_lo!=0 is misaligned.
- Illegal or misaligned: err=1 next cycle, no write, stay in IDLE.
- Otherwise: go to WAIT_LOAD, counter=0.

IDLE, no transfer:
- wen=0.
- mem_rvalid is ignored in IDLE.

WAIT_LOAD, mem_rvalid=1:
- Extract the field and extend it:
  - LB: mem_rdata[8*addr_lo +: 8], sign-extended.
  - LBU: same byte, zero-extended.
  - LH: mem_rdata[16*addr_lo[1] +: 16], sign-extended.
  - LHU: same halfword, zero-extended.
  - LW: full word.
- Next cycle: wen=1, rd=captured rd, data_out=extended value.
- Return to IDLE. A new instruction can be accepted in the cycle wen is high.

WAIT_LOAD, mem_rvalid=0:
- counter increments.
- On the cycle counter reaches TIMEOUT-1 without rvalid: err=1 next cycle, no write, return to IDLE.
- mem_rvalid arriving in that same cycle wins: the write happens, no err.

rd==0:
- Any transaction targeting x0 completes normally (handshake, state, err rules apply).
- wen stays 0 for it.

Output timing:
- wen and err are single-cycle pulses.
- rd and data_out hold their last value when wen=0.
- All outputs are registered except wb_ready and busy.

Test Plan:
- Reset then non-load: wb_rd=5, wb_result=0x1234_5678 -> next cycle wen=1, rd=5, data_out=0x12345678; following cycle wen=0.
- LB: wb_rd=7, addr_lo=3; mem_rdata=0x80FF_0011 two cycles later -> wb_ready=0 and busy=1 while waiting; write rd=7, data=0xFFFF_FF80. Same stimulus with LBU -> data=0x0000_0080.
- LH: addr_lo=2, rdata=0x8001_7FFF -> data=0xFFFF_8001. LHU with addr_lo=1 -> err pulse, no wen, wb_ready=1 next cycle.
- Timeout: load accepted, no rvalid for 16 cycles -> err pulse, no wen, back to IDLE. Variant with rvalid on the 16th waiting cycle -> write occurs, err=0.
- rd=0: non-load with wb_result=0xDEAD and an LW to x0 -> wen never asserts; handshakes complete.
- Reset mid-load: rst after 3 waiting cycles, then rvalid -> no wen, no err, wb_ready=1 after reset.
